// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM command scheduler: controller states,
// address slicing and the pin levels driven while the bus is parked.
package dram_ctrl_pkg;

  localparam int ROW_BITS = 11;
  localparam int COL_BITS = 10;

  // Byte address layout: row in [22:12], column (word) in [11:2].
  localparam int ROW_LSB = 12;
  localparam int COL_LSB = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_COL,
    S_RD1,
    S_RD2,
    S_REF
  } dram_state_e;

  localparam logic       IDLE_CSN  = 1'b1;
  localparam logic       IDLE_RASN = 1'b1;
  localparam logic       IDLE_CASN = 1'b1;
  localparam logic [3:0] IDLE_WEN  = 4'hF;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter with a saturating pending flag; the flag is
// cleared by the controller's refresh-done pulse. Built only with DRAM_REFRESH_EN.
`ifdef DRAM_REFRESH_EN
module dram_refresh_timer #(
  parameter int REF_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic refresh_done,
  output logic pending
);

  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] count;
  logic             expire;

  assign expire = (count == LAST);

  // A fresh expiry wins over a same-cycle clear so no interval is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      pending <= 1'b0;
    end else begin
      count <= expire ? '0 : count + 1'b1;
      if (expire)
        pending <= 1'b1;
      else if (refresh_done)
        pending <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/dram_arbiter.sv
// Two-port DRAM command scheduler with open-page tracking and round-robin
// arbitration. Periodic RAS-only refresh is built in when DRAM_REFRESH_EN is defined.
module dram_arbiter
  import dram_ctrl_pkg::dram_state_e, dram_ctrl_pkg::S_IDLE, dram_ctrl_pkg::S_PRE,
         dram_ctrl_pkg::S_ACT, dram_ctrl_pkg::S_COL, dram_ctrl_pkg::S_RD1,
         dram_ctrl_pkg::S_RD2, dram_ctrl_pkg::S_REF, dram_ctrl_pkg::ROW_LSB,
         dram_ctrl_pkg::COL_LSB, dram_ctrl_pkg::IDLE_CSN, dram_ctrl_pkg::IDLE_RASN,
         dram_ctrl_pkg::IDLE_CASN, dram_ctrl_pkg::IDLE_WEN;
#(
  parameter int REF_PERIOD = 1024,
  parameter int ROW_BITS   = dram_ctrl_pkg::ROW_BITS,
  parameter int COL_BITS   = dram_ctrl_pkg::COL_BITS
) (
  input  logic                clk,
  input  logic                rst,
  // Handshake: reqN is held with stable fields until the one-cycle ackN;
  // on a read, rdataN is valid only in the ackN cycle.
  input  logic                req0,
  input  logic [22:0]         addr0,
  input  logic                we0,
  input  logic [3:0]          wmask0,
  input  logic [31:0]         wdata0,
  output logic                ack0,
  output logic [31:0]         rdata0,
  input  logic                req1,
  input  logic [22:0]         addr1,
  input  logic                we1,
  input  logic [3:0]          wmask1,
  input  logic [31:0]         wdata1,
  output logic                ack1,
  output logic [31:0]         rdata1,
  input  logic [31:0]         DRAM_Q,
  output logic                DRAM_CSn,
  output logic [3:0]          DRAM_WEn,
  output logic                DRAM_RASn,
  output logic                DRAM_CASn,
  output logic [ROW_BITS-1:0] DRAM_A,
  output logic [31:0]         DRAM_D,
  output dram_state_e         state_dbg
);

  dram_state_e         state, state_nxt;
  logic                row_open;
  logic [ROW_BITS-1:0] open_row;
  logic                rr_ptr;

  logic                port_q;
  logic                we_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [3:0]          mask_q;
  logic [31:0]         wdata_q;

  // ref_busy: a refresh sequence owns the bus; pre_to_idle: the PRE after REF.
  logic                ref_busy;
  logic                pre_to_idle;
  logic                ref_pending;
  logic [ROW_BITS-1:0] ref_row;

  logic                any_req;
  logic                win_port;
  logic [ROW_BITS-1:0] win_row;
  logic                take_req;
  logic                done;

  assign any_req  = req0 | req1;
  assign win_port = (req0 && req1) ? rr_ptr : req1;
  assign win_row  = win_port ? addr1[ROW_LSB +: ROW_BITS] : addr0[ROW_LSB +: ROW_BITS];
  assign take_req = (state == S_IDLE) && !ref_pending && any_req;

  assign state_dbg = state;
  assign rdata0    = DRAM_Q;
  assign rdata1    = DRAM_Q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ref_pending)
          state_nxt = row_open ? S_PRE : S_REF;
        else if (any_req) begin
          if (row_open && (win_row == open_row))
            state_nxt = S_COL;
          else if (row_open)
            state_nxt = S_PRE;
          else
            state_nxt = S_ACT;
        end
      end
      S_PRE:   state_nxt = pre_to_idle ? S_IDLE : (ref_busy ? S_REF : S_ACT);
      S_ACT:   state_nxt = S_COL;
      S_COL:   state_nxt = we_q ? S_IDLE : S_RD1;
      S_RD1:   state_nxt = S_RD2;
      S_RD2:   state_nxt = S_IDLE;
      S_REF:   state_nxt = S_PRE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      row_open    <= 1'b0;
      open_row    <= '0;
      rr_ptr      <= 1'b0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      ref_busy    <= 1'b0;
      pre_to_idle <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_req) begin
        port_q  <= win_port;
        rr_ptr  <= ~win_port;
        row_q   <= win_row;
        col_q   <= win_port ? addr1[COL_LSB +: COL_BITS] : addr0[COL_LSB +: COL_BITS];
        we_q    <= win_port ? we1 : we0;
        mask_q  <= win_port ? wmask1 : wmask0;
        wdata_q <= win_port ? wdata1 : wdata0;
      end
      if ((state == S_IDLE) && ref_pending)
        ref_busy <= 1'b1;
      if (state == S_ACT) begin
        row_open <= 1'b1;
        open_row <= row_q;
      end
      if (state == S_PRE) begin
        row_open    <= 1'b0;
        pre_to_idle <= 1'b0;
      end
      if (state == S_REF) begin
        ref_busy    <= 1'b0;
        pre_to_idle <= 1'b1;
      end
    end
  end

  assign done = ((state == S_COL) && we_q) || (state == S_RD2);
  assign ack0 = done && !port_q;
  assign ack1 = done && port_q;

  // RAS stays low in IDLE while a page is open so page hits skip ACT.
  always_comb begin
    DRAM_CSn  = 1'b0;
    DRAM_RASn = 1'b0;
    DRAM_CASn = IDLE_CASN;
    DRAM_WEn  = IDLE_WEN;
    DRAM_A    = '0;
    DRAM_D    = '0;
    case (state)
      S_IDLE: begin
        DRAM_CSn  = row_open ? 1'b0 : IDLE_CSN;
        DRAM_RASn = row_open ? 1'b0 : IDLE_RASN;
      end
      S_PRE:  DRAM_RASn = 1'b1;
      S_ACT:  DRAM_A    = row_q;
      S_COL: begin
        DRAM_CASn = 1'b0;
        DRAM_A    = ROW_BITS'(col_q);
        if (we_q) begin
          DRAM_WEn = ~mask_q;
          DRAM_D   = wdata_q;
        end
      end
      S_RD1, S_RD2: DRAM_A = ROW_BITS'(col_q);
      S_REF:  DRAM_A = ref_row;
      default: begin
        DRAM_CSn  = IDLE_CSN;
        DRAM_RASn = IDLE_RASN;
      end
    endcase
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

`ifdef DRAM_REFRESH_EN
  logic ref_done;
  assign ref_done = (state == S_REF);

  dram_refresh_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_refresh_timer (
    .clk          (clk),
    .rst          (rst),
    .refresh_done (ref_done),
    .pending      (ref_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ref_row <= '0;
    else if (ref_done)
      ref_row <= ref_row + 1'b1;
  end
`else
  assign ref_pending = 1'b0;
  assign ref_row     = '0;

  // The period only shapes hardware when refresh is built in.
  logic unused_ref_period;
  assign unused_ref_period = (REF_PERIOD > 0);
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: reset values, hit/closed/miss timing,
// round-robin fairness, reset abort and (with DRAM_REFRESH_EN) refresh rows.
module tb_dram_arbiter;
  import dram_ctrl_pkg::*;

`ifdef DRAM_REFRESH_EN
  localparam int TB_REF_PERIOD = 16;
`else
  localparam int TB_REF_PERIOD = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [22:0] addr0, addr1;
  logic [3:0]  wmask0, wmask1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1, dram_q;
  logic        dram_csn, dram_rasn, dram_casn;
  logic [3:0]  dram_wen;
  logic [10:0] dram_a;
  logic [31:0] dram_d;
  dram_state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  dram_state_e st_tr[32];
  logic [10:0] a_tr[32];
  logic [3:0]  wen_tr[32];
  logic [31:0] d_tr[32];
  logic        rasn_tr[32], casn_tr[32], csn_tr[32];
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  dram_arbiter #(.REF_PERIOD(TB_REF_PERIOD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .we0(we0), .wmask0(wmask0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .we1(we1), .wmask1(wmask1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .DRAM_Q(dram_q), .DRAM_CSn(dram_csn), .DRAM_WEn(dram_wen), .DRAM_RASn(dram_rasn),
    .DRAM_CASn(dram_casn), .DRAM_A(dram_a), .DRAM_D(dram_d), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wmask0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wmask1 = '0; wdata1 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issues one access; cycle 0 is the IDLE cycle in which the request is seen.
  task automatic do_access(input bit port, input logic [22:0] addr, input bit we,
                           input logic [3:0] mask, input logic [31:0] data,
                           input int exp_ack);
    int ack_cyc;
    logic [31:0] q_val;
    q_val  = 32'hC0DE_0000 ^ {9'd0, addr};
    dram_q = q_val;
    if (!port) begin
      req0 = 1; addr0 = addr; we0 = we; wmask0 = mask; wdata0 = data;
    end else begin
      req1 = 1; addr1 = addr; we1 = we; wmask1 = mask; wdata1 = data;
    end
    ack_cyc = -1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      st_tr[k] = state_dbg; a_tr[k] = dram_a; wen_tr[k] = dram_wen; d_tr[k] = dram_d;
      rasn_tr[k] = dram_rasn; casn_tr[k] = dram_casn; csn_tr[k] = dram_csn;
      check("other_port_ack", port ? ack0 : ack1, 0);
      if (port ? ack1 : ack0) begin
        ack_cyc = k;
        if (!we) check("rdata", port ? rdata1 : rdata0, q_val);
        break;
      end
    end
    check("ack_cycle", ack_cyc, exp_ack);
    @(posedge clk);
    #1;
    if (!port) req0 = 0; else req1 = 0;
  endtask

  initial begin
    int first_ack, second_ack, n_ack;
    clear_inputs();
    dram_q = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_csn", dram_csn, 1);
    check("rst_wen", dram_wen, 4'hF);
    check("rst_rasn", dram_rasn, 1);
    check("rst_casn", dram_casn, 1);
    check("rst_a", dram_a, 0);
    check("rst_d", dram_d, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Closed-row write then page-hit read.
    do_access(0, 23'h000100, 1, 4'h3, 32'h1122_3344, 2);
    check("wr_c0_csn", csn_tr[0], 1);
    check("wr_c1_act", st_tr[1], S_ACT);
    check("wr_c1_a", a_tr[1], 11'h000);
    check("wr_c2_col", st_tr[2], S_COL);
    check("wr_c2_a", a_tr[2], 11'h040);
    check("wr_c2_casn", casn_tr[2], 0);
    check("wr_c2_wen", wen_tr[2], 4'hC);
    check("wr_c2_d", d_tr[2], 32'h1122_3344);
    do_access(0, 23'h000104, 0, 4'h0, 32'h0, 3);
    check("rd_c0_rasn_open", rasn_tr[0], 0);
    check("rd_c0_csn_open", csn_tr[0], 0);
    check("rd_c1_col", st_tr[1], S_COL);
    check("rd_c1_a", a_tr[1], 11'h041);
    check("rd_c1_wen", wen_tr[1], 4'hF);

    // Row miss, then a port 1 write hit on the newly opened row.
    apply_reset();
    do_access(0, 23'h000100, 1, 4'hF, 32'h0, 2);
    do_access(0, 23'h003000, 0, 4'h0, 32'h0, 5);
    check("miss_c1_pre", st_tr[1], S_PRE);
    check("miss_c1_rasn", rasn_tr[1], 1);
    check("miss_c2_act", st_tr[2], S_ACT);
    check("miss_c2_a", a_tr[2], 11'h003);
    check("miss_c3_col", st_tr[3], S_COL);
    check("miss_c3_a", a_tr[3], 11'h000);
    do_access(1, 23'h003008, 1, 4'h9, 32'hCAFE_F00D, 1);
    check("p1_c1_a", a_tr[1], 11'h002);
    check("p1_c1_wen", wen_tr[1], 4'h6);
    check("p1_c1_d", d_tr[1], 32'hCAFE_F00D);

    // Both ports held from reset: grants alternate starting with port 0.
    rst = 1'b1;
    req0 = 1; addr0 = 23'h000100; we0 = 1; wmask0 = 4'hF; wdata0 = 32'h0000_0A0A;
    req1 = 1; addr1 = 23'h000200; we1 = 1; wmask1 = 4'hF; wdata1 = 32'h0000_0B0B;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back(1'(i % 2));
    first_ack = -1; second_ack = -1; n_ack = 0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (ack0 && ack1) check("dual_ack", 2, 1);
      if (ack0 || ack1) begin
        check("grant_order", ack1, exp_q.pop_front());
        if (n_ack == 0) first_ack = k;
        if (n_ack == 1) second_ack = k;
        n_ack++;
      end
    end
    check("grants_outstanding", exp_q.size(), 0);
    check("hit_gap", second_ack - first_ack, 2);
    @(posedge clk);
    #1;
    clear_inputs();

    // Reset during RD1 aborts the read; the next access must re-activate.
    apply_reset();
    do_access(0, 23'h000100, 1, 4'hF, 32'h0, 2);
    req0 = 1; addr0 = 23'h000108; we0 = 0;
    @(negedge clk);
    @(negedge clk);
    check("abort_c1_col", state_dbg, S_COL);
    @(negedge clk);
    check("abort_c2_rd1", state_dbg, S_RD1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ack", {ack0, ack1}, 0);
    check("abort_state", state_dbg, S_IDLE);
    check("abort_pins", {dram_csn, dram_rasn, dram_casn, dram_wen}, 7'h7F);
    check("abort_a_d", {21'd0, dram_a} | dram_d, 0);
    req0 = 0;
    @(negedge clk);
    check("abort_ack_hold", {ack0, ack1}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(0, 23'h000108, 1, 4'hF, 32'h5555_AAAA, 2);
    check("abort_next_act", st_tr[1], S_ACT);

`ifdef DRAM_REFRESH_EN
    begin
      logic        last;
      int          acks;
      logic [10:0] ref_q[$];
      logic [10:0] r0, r1;
      rst = 1'b1;
      req0 = 1; addr0 = 23'h000100; we0 = 1; wmask0 = 4'hF;
      req1 = 1; addr1 = 23'h000200; we1 = 1; wmask1 = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      last = 1'b1; acks = 0;
      for (int k = 0; k < 120; k++) begin
        @(negedge clk);
        if (state_dbg == S_REF) ref_q.push_back(dram_a);
        if (ack0 || ack1) begin
          check("ref_rr_alternate", ack1, ~last);
          last = ack1;
          acks++;
        end
      end
      check("ref_seen_twice", ref_q.size() >= 2, 1);
      r0 = (ref_q.size() > 0) ? ref_q[0] : 11'h7FF;
      r1 = (ref_q.size() > 1) ? ref_q[1] : 11'h7FF;
      check("ref_row_first", r0, 0);
      check("ref_row_second", r1, 1);
      check("ref_acks_progress", acks >= 30, 1);
      @(posedge clk);
      #1;
      clear_inputs();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port DRAM command scheduler. It shares the single external DRAM pin interface between two on-chip requesters: port 0 is the AHB slave path and port 1 is the face-detection DMA engine. It tracks the open row to exploit page hits, sequences precharge/activate/column commands, and, when compiled in, inserts periodic RAS-only refresh. It sits between the requesters and the chip-level DRAM pads.

## Interface
Parameters:
- REF_PERIOD, 1024: cycles between refresh requests.
- ROW_BITS, 11: row address width, taken from addr[22:12].
- COL_BITS, 10: column address width, taken from addr[11:2].

Ports (N = 0, 1):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqN  in  1  request; held with fields stable until ackN
- addrN  in  23  byte address
- weN  in  1  1 = write, 0 = read
- wmaskN  in  4  active-high byte enables for writes
- wdataN  in  32  write data
- ackN  out  1  one-cycle completion pulse
- rdataN  out  32  read data; valid when ackN is high on a read
- DRAM_Q  in  32  DRAM read data
- DRAM_CSn  out  1  chip select, active low
- DRAM_WEn  out  4  byte write enables, active low
- DRAM_RASn  out  1  row strobe, active low
- DRAM_CASn  out  1  column strobe, active low
- DRAM_A  out  11  multiplexed row/column address
- DRAM_D  out  32  write data

## Operation
- States:
  - IDLE
  - PRE: RASn=1 for one cycle; closes the open row.
  - ACT: RASn=0, A=row.
  - COL: RASn=0, CASn=0, A={1'b0,col}; on a write also WEn=~wmask and D=wdata.
  - RD1, RD2: RASn=0 held.
  - REF: RASn=0, A=ref_row.
- Page tracking:
  - row_open flag and open_row register.
  - RASn is held low in IDLE while row_open=1.
- IDLE decision, taken in priority order:
  - Refresh pending: go to PRE if a row is open, else to REF.
  - Otherwise a request wins: hit (row_open and row matches) goes to COL; closed row goes to ACT; open row that misses goes to PRE, then ACT.
- Request capture: the winner's port, address, we, mask and data are latched on the decision edge. Later changes on the port are ignored until ack.
- Completion:
  - Write: ackN pulses in the COL cycle, then IDLE.
  - Read: COL → RD1 → RD2. In RD2, ackN=1 and rdataN=DRAM_Q, then IDLE.
- Arbitration: round-robin pointer, reset to 0.
  - With both requests high, the pointer's port wins and the pointer then toggles to the other port.
  - With a single request, that port wins and the pointer moves to the other port.
- rdataN is continuously DRAM_Q. The requester qualifies it with ackN.
- DRAM_CSn = 0 in every state except IDLE with row_open=0.
- Reset values: all ack outputs 0; CSn=1, WEn=4'hF, RASn=1, CASn=1, A=0, D=0. State IDLE, row_open=0, pointer 0, ref_row 0, refresh counter 0.
- Reset asserted mid-transaction aborts it: no ack is issued and the row is treated as closed.

## Timing
Request seen in IDLE at cycle 0:
- Write hit: COL and ack in cycle 1.
- Read hit: COL in cycle 1, ack in cycle 3.
- Closed-row access: ACT in cycle 1, COL in cycle 2. Write ack in cycle 2, read ack in cycle 4.
- Row miss: PRE in cycle 1, ACT in cycle 2, COL in cycle 3. Write ack in cycle 3, read ack in cycle 5.
- Refresh: (PRE) → REF → PRE → IDLE with row_open=0, adding 2–3 cycles. ref_row increments and wraps 2047→0.
- Back-to-back accesses: the next decision is made in the IDLE cycle following completion, giving a minimum of 2 cycles per write hit.
- A refresh never interrupts a transaction in progress. It waits for IDLE.
- Refresh flag saturates: if the counter expires while a refresh is already pending, the flag stays 1 and no second refresh is queued.

## Configuration
- DRAM_REFRESH_EN defined: refresh timer, pending flag, REF state and ref_row are present.
- DRAM_REFRESH_EN undefined: no refresh logic. The pending flag is constant 0 and REF is unreachable.

## Structure
- Shared package dram_ctrl_pkg holds:
  - the state enum;
  - ROW_BITS and COL_BITS;
  - row/column slice localparams;
  - idle pin constants.
- Sub-module dram_refresh_timer (REF_PERIOD counter and saturating pending flag, cleared by a refresh-done pulse) is instantiated only under DRAM_REFRESH_EN.

## Test plan
- After reset, req0 write to 0x000100 with wmask=4'h3: ACT A=0 in cycle 1, COL A=0x040 with WEn=4'hC in cycle 2, ack0 in cycle 2.
- Read 0x000104 immediately after: row hit, COL in cycle 1, ack0 and rdata0=DRAM_Q in cycle 3.
- Read 0x003000 with row 0 open: PRE, then ACT A=3, then COL A=0, ack in cycle 5.
- req0 and req1 both held from reset: grants alternate 0,1,0,1 and neither port starves.
- With DRAM_REFRESH_EN and REF_PERIOD=16, under continuous requests: a REF with A=0 occurs, then later A=1; no ack is lost or duplicated.
- Reset asserted during RD1: no ack, all outputs return to reset values; the next access issues ACT.
